// File: rtl/colour_seq_if.sv
// Controller-side bundle for colour_seq_player: sequence append handshake,
// playback control, status and lamp drive.
interface colour_seq_if #(
  parameter int CODE_W = 2,
  parameter int DEPTH  = 16
);
  localparam int OUT_W = 2 ** CODE_W;
  localparam int LEN_W = $clog2(DEPTH) + 1;

  // Append handshake: a code transfers on a rising edge where wr_valid && wr_ready.
  // wr_ready is combinational and never waits on wr_valid; a write offered
  // while wr_ready is low is dropped rather than held, so the master must re-offer it.
  logic              oe;
  logic              wr_valid;
  logic [CODE_W-1:0] wr_code;
  logic              wr_ready;
  logic              play_start;
  logic              clear;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  seq_len;
  logic [OUT_W-1:0]  lamp;
  logic [1:0]        dbg_state;

  modport master (
    output oe, wr_valid, wr_code, play_start, clear,
    input  wr_ready, busy, done, seq_len, lamp, dbg_state
  );

  modport slave (
    input  oe, wr_valid, wr_code, play_start, clear,
    output wr_ready, busy, done, seq_len, lamp, dbg_state
  );
endinterface

// File: rtl/colour_seq_player.sv
// Stores a sequence of colour codes and plays it back as timed one-hot lamp
// pulses (ON_CYCLES lit, OFF_CYCLES dark per code).
module colour_seq_player #(
  parameter int CODE_W     = 2,
  parameter int DEPTH      = 16,
  parameter int ON_CYCLES  = 1000,
  parameter int OFF_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  colour_seq_if.slave bus
);
  localparam int OUT_W = 2 ** CODE_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int LEN_W = AW + 1;
  localparam int CMAX  = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW    = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [TW-1:0]    ON_LOAD   = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]    OFF_LOAD  = TW'(OFF_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_FULL  = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  seq_len_q, seq_len_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [OUT_W-1:0]  lamp_q, lamp_d;
  logic              done_q, done_d;

  logic [CODE_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic              wr_ready;
  logic [AW-1:0]     idx_next;
  logic              last_code;

  function automatic logic [OUT_W-1:0] onehot(input logic [CODE_W-1:0] code);
    onehot = OUT_W'(1) << code;
  endfunction

  assign wr_ready  = (state_q == ST_IDLE) && (seq_len_q < LEN_FULL)
                     && !bus.play_start && !bus.clear;
  assign idx_next  = idx_q + AW'(1);
  assign last_code = ({1'b0, idx_q} == (seq_len_q - LEN_ONE));

  always_comb begin
    state_d   = state_q;
    seq_len_d = seq_len_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    lamp_d    = lamp_q;
    done_d    = 1'b0;
    wr_en     = 1'b0;

    // clear outranks everything, including writes and play requests in the same cycle
    if (bus.clear) begin
      state_d   = ST_IDLE;
      seq_len_d = '0;
      idx_d     = '0;
      timer_d   = '0;
      lamp_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.play_start) begin
            if (seq_len_q == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_ON;
              idx_d   = '0;
              lamp_d  = onehot(mem[0]);
              timer_d = ON_LOAD;
            end
          end else if (bus.wr_valid && wr_ready) begin
            wr_en     = 1'b1;
            seq_len_d = seq_len_q + LEN_ONE;
          end
        end
        ST_ON: begin
          if (timer_q == '0) begin
            state_d = ST_OFF;
            lamp_d  = '0;
            timer_d = OFF_LOAD;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        ST_OFF: begin
          if (timer_q == '0) begin
            if (last_code) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_ON;
              idx_d   = idx_next;
              lamp_d  = onehot(mem[idx_next]);
              timer_d = ON_LOAD;
            end
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          lamp_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      seq_len_q <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      lamp_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_len_q <= seq_len_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      lamp_q    <= lamp_d;
      done_q    <= done_d;
    end
  end

  // Sequence storage is deliberately left out of reset; seq_len guards every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[seq_len_q[AW-1:0]] <= bus.wr_code;
    end
  end

  assign bus.wr_ready  = wr_ready;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.seq_len   = seq_len_q;
  assign bus.lamp      = bus.oe ? lamp_q : '0;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_colour_seq_player.sv
// Directed bench for colour_seq_player with short ON/OFF timing (3/2 cycles).
module tb_colour_seq_player;
  localparam int CODE_W = 2;
  localparam int DEPTH  = 16;
  localparam int ON     = 3;
  localparam int OFF    = 2;
  localparam int PER    = ON + OFF;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [CODE_W-1:0] exp_q[$];
  bit                oe_model;
  logic [3:0]        last_tr [0:127];

  colour_seq_if #(.CODE_W(CODE_W), .DEPTH(DEPTH)) bus ();

  colour_seq_player #(
    .CODE_W(CODE_W), .DEPTH(DEPTH), .ON_CYCLES(ON), .OFF_CYCLES(OFF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, still running (required: finished)");
    $fatal(1, "watchdog");
  end

  task automatic write_code(input logic [CODE_W-1:0] c);
    bus.wr_valid = 1'b1;
    bus.wr_code  = c;
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
    exp_q.push_back(c);
  endtask

  task automatic pulse_play();
    bus.play_start = 1'b1;
    @(posedge clk); #1;
    bus.play_start = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    exp_q.delete();
  endtask

  // Plays exp_q once and checks lamp/busy/done every cycle against the timing model.
  task automatic play_and_check(input string name);
    int         len;
    int         i;
    int         ph;
    logic [3:0] el;
    logic       eb;
    logic       ed;
    len = exp_q.size();
    pulse_play();
    for (int c = 1; c <= len * PER + 2; c++) begin
      @(negedge clk);
      el = 4'b0000; eb = 1'b0; ed = 1'b0;
      if (c <= len * PER) begin
        i  = (c - 1) / PER;
        ph = (c - 1) % PER;
        eb = 1'b1;
        if (ph < ON && oe_model) el = 4'b0001 << exp_q[i];
      end else if (c == len * PER + 1) begin
        ed = 1'b1;
      end
      last_tr[c] = bus.lamp;
      n_checks++;
      if (bus.lamp !== el) begin
        n_fail++;
        $display("FAIL %s lamp cycle %0d: got %b, expected %b", name, c, bus.lamp, el);
      end
      n_checks++;
      if (bus.busy !== eb) begin
        n_fail++;
        $display("FAIL %s busy cycle %0d: got %b, expected %b", name, c, bus.busy, eb);
      end
      n_checks++;
      if (bus.done !== ed) begin
        n_fail++;
        $display("FAIL %s done cycle %0d: got %b, expected %b", name, c, bus.done, ed);
      end
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (bus.lamp !== 4'b0 || bus.busy !== 1'b0 || bus.seq_len !== 5'd0 ||
        bus.done !== 1'b0 || bus.dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_initial: lamp=%b busy=%b len=%0d done=%b st=%0d, expected all 0",
               bus.lamp, bus.busy, bus.seq_len, bus.done, bus.dbg_state);
    end
    @(negedge clk); rst_n = 1'b1;
    write_code(2'd3);
    pulse_play();
    @(posedge clk); #1;
    n_checks++;
    if (bus.lamp !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_pre_on: lamp got %b, expected 1000", bus.lamp);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.lamp !== 4'b0 || bus.busy !== 1'b0 || bus.seq_len !== 5'd0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: lamp=%b busy=%b len=%0d done=%b, expected all 0",
               bus.lamp, bus.busy, bus.seq_len, bus.done);
    end
    @(negedge clk); rst_n = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.lamp !== 4'b0 || bus.busy !== 1'b0 || bus.seq_len !== 5'd0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after_release: lamp=%b busy=%b len=%0d done=%b, expected all 0",
               bus.lamp, bus.busy, bus.seq_len, bus.done);
    end
  endtask

  task automatic test_basic();
    write_code(2'd2);
    write_code(2'd0);
    n_checks++;
    if (bus.seq_len !== 5'd2) begin
      n_fail++;
      $display("FAIL basic_len: got %0d, expected 2", bus.seq_len);
    end
    play_and_check("basic");
  endtask

  task automatic test_full_replay();
    int         accepted;
    logic [3:0] first_tr [0:127];
    int         diff;
    logic [CODE_W-1:0] c;
    do_clear();
    accepted = 0;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      c = CODE_W'((i * 3 + i / 4) % 4);
      bus.wr_code = c;
      exp_q.push_back(c);
      @(negedge clk);
      if (bus.wr_ready === 1'b1) accepted++;
      @(posedge clk); #1;
    end
    bus.wr_code = 2'd1;
    @(negedge clk);
    n_checks++;
    if (bus.wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: got %b, expected 0", bus.wr_ready);
    end
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
    n_checks++;
    if (accepted != DEPTH) begin
      n_fail++;
      $display("FAIL full_accepted: got %0d, expected %0d", accepted, DEPTH);
    end
    n_checks++;
    if (bus.seq_len !== 5'd16) begin
      n_fail++;
      $display("FAIL full_len: got %0d, expected 16", bus.seq_len);
    end
    play_and_check("full_play1");
    for (int k = 1; k <= DEPTH * PER + 2; k++) first_tr[k] = last_tr[k];
    play_and_check("full_play2");
    diff = 0;
    for (int k = 1; k <= DEPTH * PER + 2; k++) if (first_tr[k] !== last_tr[k]) diff++;
    n_checks++;
    if (diff != 0) begin
      n_fail++;
      $display("FAIL replay_identical: %0d differing cycles, expected 0", diff);
    end
  endtask

  task automatic test_empty();
    do_clear();
    pulse_play();
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_pulse: done=%b busy=%b, expected done=1 busy=0", bus.done, bus.busy);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_after: done=%b busy=%b, expected 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_collision();
    bit got_done;
    write_code(2'd1);
    bus.wr_valid   = 1'b1;
    bus.wr_code    = 2'd2;
    bus.play_start = 1'b1;
    #1;
    n_checks++;
    if (bus.wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_ready: got %b, expected 0", bus.wr_ready);
    end
    @(posedge clk); #1;
    bus.wr_valid   = 1'b0;
    bus.play_start = 1'b0;
    n_checks++;
    if (bus.seq_len !== 5'd1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_len: len=%0d busy=%b, expected 1 1", bus.seq_len, bus.busy);
    end
    got_done = 1'b0;
    for (int k = 0; k < 50 && !got_done; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) got_done = 1'b1;
    end
    n_checks++;
    if (!got_done) begin
      n_fail++;
      $display("FAIL collision_done: no done within 50 cycles, expected one");
    end
    play_and_check("collision_replay");
  endtask

  task automatic test_abort();
    bit saw_done;
    do_clear();
    write_code(2'd1);
    write_code(2'd2);
    write_code(2'd3);
    pulse_play();
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (bus.lamp !== 4'b0100) begin
      n_fail++;
      $display("FAIL abort_second_on: lamp got %b, expected 0100", bus.lamp);
    end
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    exp_q.delete();
    n_checks++;
    if (bus.lamp !== 4'b0 || bus.busy !== 1'b0 || bus.seq_len !== 5'd0) begin
      n_fail++;
      $display("FAIL abort_state: lamp=%b busy=%b len=%0d, expected 0 0 0",
               bus.lamp, bus.busy, bus.seq_len);
    end
    saw_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL abort_no_done: done pulse seen, expected none");
    end
  endtask

  task automatic test_oe();
    int done_cycle;
    do_clear();
    write_code(2'd3);
    write_code(2'd1);
    bus.oe   = 1'b0;
    oe_model = 1'b0;
    play_and_check("oe_off");
    pulse_play();
    @(posedge clk); #1;
    n_checks++;
    if (bus.lamp !== 4'b0) begin
      n_fail++;
      $display("FAIL oe_low_lamp: got %b, expected 0000", bus.lamp);
    end
    bus.oe   = 1'b1;
    oe_model = 1'b1;
    #1;
    n_checks++;
    if (bus.lamp !== 4'b1000) begin
      n_fail++;
      $display("FAIL oe_raise_lamp: got %b, expected 1000", bus.lamp);
    end
    done_cycle = -1;
    for (int c = 2; c < 40 && done_cycle < 0; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cycle = c;
    end
    n_checks++;
    if (done_cycle != 2 * PER + 1) begin
      n_fail++;
      $display("FAIL oe_done_timing: done at cycle %0d, expected %0d", done_cycle, 2 * PER + 1);
    end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    oe_model       = 1'b1;
    rst_n          = 1'b0;
    bus.oe         = 1'b1;
    bus.wr_valid   = 1'b0;
    bus.wr_code    = '0;
    bus.play_start = 1'b0;
    bus.clear      = 1'b0;
    test_reset();
    test_basic();
    test_full_replay();
    test_empty();
    test_collision();
    test_abort();
    test_oe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/colour_seq_player.md
Name: colour_seq_player

Overview:
Parametrised colour-lamp sequencer. It stores a sequence of binary colour codes and plays them back as timed one-hot lamp pulses, with an off gap between colours. It is the successor to the fixed 2-bit, 4-lamp colour decode: the code width, sequence depth and on/off timing are generic, and playback is clocked. It sits between the game controller, which appends codes and requests playback, and the output pins.

Parameters:
CODE_W, 2, colour code width; lamp count OUT_W = 2**CODE_W (localparam)
DEPTH, 16, maximum stored sequence length (power of two, >=2)
ON_CYCLES, 1000, clock cycles each lamp is lit (>=1)
OFF_CYCLES, 500, clock cycles of dark gap after each lamp (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
oe  input  1  output enable, active high; when low, lamp is forced to 0
wr_valid  input  1  append request for wr_code
wr_code  input  CODE_W  colour code to append
wr_ready  output  1  append accepted when wr_valid && wr_ready at a rising edge
play_start  input  1  single-cycle request to play the stored sequence
clear  input  1  empty the sequence; aborts any playback
busy  output  1  playback in progress
done  output  1  one-cycle pulse when playback completes normally
seq_len  output  clog2(DEPTH)+1  number of stored codes
lamp  output  OUT_W  one-hot lamp drive; bit k lit for code k

Behaviour:
- Reset (async, rst_n=0): state IDLE, seq_len=0, idx=0, timer=0, lamp register=0, done=0, busy=0. Memory contents are not reset.
- wr_ready = (state==IDLE) && (seq_len<DEPTH) && !play_start && !clear. This is combinational.
- Accepted write: mem[seq_len] <= wr_code; seq_len += 1. Writes while not ready are ignored, not queued.
- States: IDLE, ON, OFF. busy = (state != IDLE).
- play_start is only honoured in IDLE.
  - If seq_len==0: stay IDLE and pulse done in the next cycle.
  - Otherwise, on the next edge: state=ON, idx=0, lamp register=onehot(mem[0]), timer=ON_CYCLES-1.
- ON: timer decrements each cycle. At timer==0, go to OFF, lamp register=0, timer=OFF_CYCLES-1. Each lamp is lit for exactly ON_CYCLES cycles.
- OFF: timer decrements each cycle. At timer==0:
  - If idx==seq_len-1: go to IDLE and set done=1 for one cycle.
  - Else: idx+1, go to ON, lamp register=onehot(mem[idx+1]), timer=ON_CYCLES-1.
- play_start while busy is ignored. The sequence is not consumed by playback and can be replayed.
- Total playback length is seq_len*(ON_CYCLES+OFF_CYCLES) cycles. busy is high for exactly that many cycles, starting the cycle after play_start. done asserts in the cycle after busy falls.
- clear (any state, highest priority):
  - Next edge: state=IDLE, seq_len=0, idx=0, lamp register=0.
  - No done pulse.
  - A wr_valid or play_start in the same cycle is dropped.
- lamp = oe ? lamp register : 0, combinational gating only. Toggling oe never disturbs sequencing or timers.
- Full: seq_len==DEPTH, so wr_ready=0. The seq_len counter is CODE-independent and never wraps.
- Exactly one lamp bit is high during ON (with oe=1). All lamp bits are 0 in OFF and IDLE.

Test Plan:
- Reset values: apply rst_n=0 mid-ON (CODE_W=2, ON=3, OFF=2) -> lamp=0, busy=0, seq_len=0, done=0 immediately (async), and they stay so after release.
- Basic playback: write codes 2,0 then pulse play_start at cycle 0 ->
  - lamp=4'b0100 in cycles 1-3 and 0 in cycles 4-5;
  - lamp=4'b0001 in cycles 6-8 and 0 in cycles 9-10;
  - busy high in cycles 1-10; done=1 in cycle 11 only.
- Full and replay: write 16 codes with wr_valid held high -> 16 accepted, seq_len=16, wr_ready=0. A 17th write is ignored. A second play_start after done replays an identical lamp trace.
- Empty and collisions:
  - play_start with seq_len=0 -> done pulse next cycle, busy never high.
  - wr_valid and play_start in the same cycle -> wr_ready=0, write dropped, seq_len unchanged.
- Abort: clear asserted during the second ON of a 3-code sequence -> next cycle lamp=0, busy=0, seq_len=0, and no done pulse.
- oe gating: oe=0 throughout playback -> lamp stays 0, but busy/done timing matches the oe=1 run. Raising oe mid-ON shows the correct one-hot value immediately.
